// File: rtl/load_store_unit.sv
// Load/store unit: responder to the control unit's cyc/ack handshake and a
// Wishbone-classic master. One bus transfer per request. Load data is aligned
// and extended here. Store data is replicated onto the byte lanes.

package global_pkg;
  typedef enum logic [1:0] {
    MEM_NONE   = 2'd0,
    LOAD_DATA  = 2'd1,
    STORE_DATA = 2'd2
  } memory_operation_t;
endpackage

module load_store_unit
  import global_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cyc,
  output logic              ack,
  input  memory_operation_t memory_operation,
  input  logic [2:0]        funct3,
  input  logic [31:0]       base,
  input  logic [31:0]       offset,
  input  logic [31:0]       store_data,
  output logic [31:0]       load_data,
  output logic              error,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [31:0]       wb_adr_o,
  output logic [3:0]        wb_sel_o,
  output logic [31:0]       wb_dat_o,
  input  logic [31:0]       wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Byte-enable pattern for an access of the given size at byte offset lo.
  function automatic logic [3:0] f_sel(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] s;
    case (size)
      2'b00:   s = 4'b0001 << lo;
      2'b01:   s = 4'b0011 << lo;
      2'b10:   s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  // Replicate the store operand across all lanes so the slave picks by sel.
  function automatic logic [31:0] f_store_dat(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] r;
    case (size)
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Pick the addressed byte/half from the bus word and sign/zero extend it.
  function automatic logic [31:0] f_load_extract(input logic [31:0] d, input logic [2:0] f3,
                                                 input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'b00:   b = d[7:0];
      2'b01:   b = d[15:8];
      2'b10:   b = d[23:16];
      default: b = d[31:24];
    endcase
    h = lo[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = d;
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  state_t        r_state;
  logic          r_ack;
  logic          r_error;
  logic [31:0]   r_load_data;
  logic          r_wb_cyc;
  logic          r_wb_we;
  logic [31:0]   r_wb_adr;
  logic [3:0]    r_wb_sel;
  logic [31:0]   r_wb_dat;
  logic [TW-1:0] r_tmo;
  logic [1:0]    r_ea_lo;
  logic [2:0]    r_funct3;
  logic          r_is_load;
  logic          r_abort;

  logic [31:0]   w_ea;
  logic          w_is_load;
  logic          w_is_store;
  logic          w_legal;
  logic          w_misaligned;
  logic          w_bus_done;

  assign w_ea       = base + offset;
  assign w_is_load  = (memory_operation == LOAD_DATA);
  assign w_is_store = (memory_operation == STORE_DATA);
  assign w_bus_done = wb_ack_i | wb_err_i | (r_tmo == TMO_LAST);

  // Legality of funct3 for the requested direction and natural alignment.
  always_comb begin
    w_legal = 1'b0;
    if (w_is_load) begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
        default:                                w_legal = 1'b0;
      endcase
    end else if (w_is_store) begin
      w_legal = (funct3 <= 3'b010);
    end else begin
      w_legal = 1'b0;
    end
    w_misaligned = ((funct3[1:0] == 2'b01) && w_ea[0]) ||
                   ((funct3[1:0] == 2'b10) && (w_ea[1:0] != 2'b00));
  end

  // Transfer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ack       <= 1'b0;
      r_error     <= 1'b0;
      r_load_data <= 32'd0;
      r_wb_cyc    <= 1'b0;
      r_wb_we     <= 1'b0;
      r_wb_adr    <= 32'd0;
      r_wb_sel    <= 4'd0;
      r_wb_dat    <= 32'd0;
      r_tmo       <= '0;
      r_ea_lo     <= 2'd0;
      r_funct3    <= 3'd0;
      r_is_load   <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ack <= 1'b0;
          if (cyc && (memory_operation != MEM_NONE)) begin
            r_load_data <= 32'd0;
            r_ea_lo     <= w_ea[1:0];
            r_funct3    <= funct3;
            r_is_load   <= w_is_load;
            r_tmo       <= '0;
            r_abort     <= 1'b0;
            if (!w_legal || w_misaligned) begin
              r_error <= 1'b1;
              r_ack   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_error  <= 1'b0;
              r_wb_cyc <= 1'b1;
              r_wb_we  <= w_is_store;
              r_wb_adr <= {w_ea[31:2], 2'b00};
              r_wb_sel <= f_sel(funct3[1:0], w_ea[1:0]);
              r_wb_dat <= w_is_store ? f_store_dat(funct3[1:0], store_data) : 32'd0;
              r_state  <= S_BUS;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_BUS: begin
          if (!cyc) begin
            r_abort <= 1'b1;
          end else begin
            r_abort <= r_abort;
          end
          if (w_bus_done) begin
            r_wb_cyc <= 1'b0;
            // Error takes priority over ack; no response at all means timeout.
            r_error  <= wb_err_i | ~wb_ack_i;
            if (wb_ack_i && !wb_err_i && r_is_load) begin
              r_load_data <= f_load_extract(wb_dat_i, r_funct3, r_ea_lo);
            end else begin
              r_load_data <= 32'd0;
            end
            if (r_abort || !cyc) begin
              r_state <= S_IDLE;
            end else begin
              r_ack   <= 1'b1;
              r_state <= S_DONE;
            end
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_DONE: begin
          if (!cyc) begin
            r_ack   <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_ack <= 1'b1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_ack    <= 1'b0;
          r_wb_cyc <= 1'b0;
        end
      endcase
    end
  end

  assign ack       = r_ack;
  assign error     = r_error;
  assign load_data = r_load_data;
  assign wb_cyc_o  = r_wb_cyc;
  assign wb_stb_o  = r_wb_cyc;
  assign wb_we_o   = r_wb_we;
  assign wb_adr_o  = r_wb_adr;
  assign wb_sel_o  = r_wb_sel;
  assign wb_dat_o  = r_wb_dat;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver pushes expected bus and
// response records, a monitor pops them as the DUT presents them.

module tb_load_store_unit;
  import global_pkg::*;

  localparam int TMO = 255;

  logic clk = 1'b0;
  logic rst;
  logic cyc;
  logic ack;
  memory_operation_t memory_operation;
  logic [2:0]  funct3;
  logic [31:0] base, offset, store_data, load_data;
  logic error;
  logic wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic wb_ack_i, wb_err_i;

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .cyc(cyc), .ack(ack), .memory_operation(memory_operation),
    .funct3(funct3), .base(base), .offset(offset), .store_data(store_data),
    .load_data(load_data), .error(error), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    bit          tmo;
  } bus_exp_t;

  typedef struct {
    logic        err;
    logic [31:0] ld;
    bit          chk_ld;
  } rsp_exp_t;

  bus_exp_t bus_q[$];
  rsp_exp_t rsp_q[$];
  int errors = 0;
  int checks = 0;

  // slave behaviour: 0 ack, 1 err, 2 ack+err, 3 never respond
  int          s_mode = 0;
  int          s_wait = 0;
  logic [31:0] s_data = 32'd0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Wishbone slave, driven on the falling edge
  initial begin
    int wcnt;
    wcnt = 0;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = 32'd0;
    forever begin
      @(negedge clk);
      wb_dat_i = s_data;
      if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i) begin
        if (wcnt >= s_wait) begin
          wb_ack_i = (s_mode == 0) || (s_mode == 2);
          wb_err_i = (s_mode == 1) || (s_mode == 2);
        end else begin
          wcnt++;
        end
      end else begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Monitor: compares bus cycles and responses against the queues
  initial begin
    logic prev_cyc, prev_ack;
    bit cur_tmo;
    int len;
    bus_exp_t be;
    rsp_exp_t re;
    prev_cyc = 1'b0; prev_ack = 1'b0; cur_tmo = 0; len = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev_cyc = 1'b0; prev_ack = 1'b0; cur_tmo = 0;
        continue;
      end
      if (wb_cyc_o && !prev_cyc) begin
        if (bus_q.size() == 0) begin
          check32("unexpected_bus_cycle", 32'd1, 32'd0);
        end else begin
          be = bus_q.pop_front();
          check32("wb_stb", {31'd0, wb_stb_o}, 32'd1);
          check32("wb_we", {31'd0, wb_we_o}, {31'd0, be.we});
          check32("wb_adr", wb_adr_o, be.adr);
          check32("wb_sel", {28'd0, wb_sel_o}, {28'd0, be.sel});
          if (be.we) check32("wb_dat_o", wb_dat_o, be.dat);
          cur_tmo = be.tmo;
          len = 0;
        end
      end
      if (wb_cyc_o) len++;
      if (!wb_cyc_o && prev_cyc && cur_tmo) begin
        check32("timeout_len", len, TMO);
        cur_tmo = 0;
      end
      if (ack && !prev_ack) begin
        if (rsp_q.size() == 0) begin
          check32("unexpected_ack", 32'd1, 32'd0);
        end else begin
          re = rsp_q.pop_front();
          check32("error", {31'd0, error}, {31'd0, re.err});
          if (re.chk_ld) check32("load_data", load_data, re.ld);
        end
      end
      prev_cyc = wb_cyc_o;
      prev_ack = ack;
    end
  end

  // Reference model: derives the expected bus record and response.
  task automatic predict(input memory_operation_t op, input logic [2:0] f3, input logic [31:0] b,
                         input logic [31:0] o, input logic [31:0] sd, input int mode,
                         input logic [31:0] data, input bit push_rsp);
    logic [31:0] ea, sh, ld;
    int nbytes, lo;
    bit legal, mis, is_ld;
    bus_exp_t be;
    rsp_exp_t re;
    ea = b + o;
    lo = int'(ea % 4);
    is_ld = (op == LOAD_DATA);
    legal = is_ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 <= 3'd2);
    nbytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    mis = (ea % nbytes) != 0;
    sh = data >> (8 * lo);
    if (nbytes == 1) ld = f3[2] ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
    else if (nbytes == 2) ld = f3[2] ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
    else ld = data;
    if (legal && !mis) begin
      be.we  = !is_ld;
      be.adr = ea & 32'hFFFF_FFFC;
      be.sel = 4'(((1 << nbytes) - 1) << lo);
      be.dat = (nbytes == 1) ? {4{sd[7:0]}} : (nbytes == 2) ? {2{sd[15:0]}} : sd;
      be.tmo = (mode == 3);
      bus_q.push_back(be);
      re.err = (mode != 0);
    end else begin
      re.err = 1'b1;
    end
    re.ld = is_ld ? ld : 32'd0;
    re.chk_ld = !re.err;
    if (push_rsp) rsp_q.push_back(re);
  endtask

  task automatic run_txn(input memory_operation_t op, input logic [2:0] f3, input logic [31:0] b,
                         input logic [31:0] o, input logic [31:0] sd, input int mode,
                         input int wt, input logic [31:0] data);
    int n;
    s_mode = mode; s_wait = wt; s_data = data;
    predict(op, f3, b, o, sd, mode, data, 1);
    @(negedge clk);
    memory_operation = op; funct3 = f3; base = b; offset = o; store_data = sd;
    cyc = 1'b1;
    n = 0;
    while (!ack && n < TMO + 40) begin @(negedge clk); n++; end
    if (!ack) begin
      check32("ack_wait_bound", 32'd0, 32'd1);
    end else begin
      repeat (3) @(negedge clk);
      check32("ack_held", {31'd0, ack}, 32'd1);
    end
    cyc = 1'b0;
    n = 0;
    while (ack && n < 5) begin @(negedge clk); n++; end
    if (ack) check32("ack_fall_bound", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int n;
    memory_operation_t rop;
    rst = 1'b1; cyc = 1'b0; memory_operation = MEM_NONE; funct3 = 3'd0;
    base = 32'd0; offset = 32'd0; store_data = 32'd0;
    repeat (3) @(negedge clk);
    check32("rst_outputs", {load_data | wb_adr_o | wb_dat_o},  32'd0);
    check32("rst_ctrl", {24'd0, ack, error, wb_cyc_o, wb_stb_o, wb_we_o, 3'd0} | {28'd0, wb_sel_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_txn(LOAD_DATA, 3'b010, 32'hF0, 32'h10, 32'd0, 0, 1, 32'hDEADBEEF);
    run_txn(LOAD_DATA, 3'b000, 32'h203, 32'h0, 32'd0, 0, 0, 32'h80123456);
    run_txn(LOAD_DATA, 3'b100, 32'h203, 32'h0, 32'd0, 0, 0, 32'h80123456);
    run_txn(STORE_DATA, 3'b000, 32'h1000, 32'h1, 32'h000000AB, 0, 0, 32'd0);
    run_txn(STORE_DATA, 3'b001, 32'h1000, 32'h2, 32'h00001234, 0, 2, 32'd0);
    run_txn(LOAD_DATA, 3'b010, 32'h100, 32'h2, 32'd0, 0, 0, 32'd0);
    run_txn(LOAD_DATA, 3'b001, 32'h101, 32'h0, 32'd0, 0, 0, 32'd0);
    run_txn(LOAD_DATA, 3'b011, 32'h100, 32'h0, 32'd0, 0, 0, 32'd0);
    run_txn(STORE_DATA, 3'b100, 32'h100, 32'h0, 32'd0, 0, 0, 32'd0);
    run_txn(LOAD_DATA, 3'b010, 32'h400, 32'h0, 32'd0, 3, 0, 32'd0);
    run_txn(LOAD_DATA, 3'b101, 32'h402, 32'h0, 32'd0, 1, 1, 32'h8000FFFF);
    run_txn(LOAD_DATA, 3'b001, 32'h402, 32'h0, 32'd0, 2, 0, 32'h8000FFFF);
    run_txn(LOAD_DATA, 3'b001, 32'hFFFFFFFF, 32'h3, 32'd0, 0, 0, 32'h0000F00D);

    // MEM_NONE with cyc high: no bus cycle, no ack
    @(negedge clk);
    memory_operation = MEM_NONE; cyc = 1'b1;
    repeat (6) @(negedge clk);
    check32("mem_none_ack", {30'd0, ack, wb_cyc_o}, 32'd0);
    cyc = 1'b0;
    @(negedge clk);

    // reset while the bus cycle is open
    s_mode = 0; s_wait = 10; s_data = 32'h11111111;
    predict(LOAD_DATA, 3'b010, 32'h800, 32'h0, 32'd0, 0, 32'h11111111, 0);
    memory_operation = LOAD_DATA; funct3 = 3'b010; base = 32'h800; offset = 32'h0;
    cyc = 1'b1;
    n = 0;
    while (!wb_cyc_o && n < 10) begin @(negedge clk); n++; end
    @(negedge clk);
    check32("bus_open_before_rst", {31'd0, wb_cyc_o}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check32("rst_mid_bus", {26'd0, ack, error, wb_cyc_o, wb_stb_o, wb_we_o, 1'b0} | {28'd0, wb_sel_o}
                           | load_data | wb_adr_o | wb_dat_o, 32'd0);
    @(negedge clk);
    rst = 1'b0; cyc = 1'b0;
    repeat (4) @(negedge clk);
    check32("no_ack_after_rst", {31'd0, ack}, 32'd0);
    run_txn(LOAD_DATA, 3'b010, 32'h800, 32'h4, 32'd0, 0, 1, 32'hCAFEF00D);

    // cyc withdrawn during the bus cycle: bus completes, no ack
    s_mode = 0; s_wait = 4; s_data = 32'h22222222;
    predict(LOAD_DATA, 3'b010, 32'h900, 32'h0, 32'd0, 0, 32'h22222222, 0);
    memory_operation = LOAD_DATA; funct3 = 3'b010; base = 32'h900; offset = 32'h0;
    cyc = 1'b1;
    n = 0;
    while (!wb_cyc_o && n < 10) begin @(negedge clk); n++; end
    cyc = 1'b0;
    n = 0;
    while (wb_cyc_o && n < 20) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    check32("abort_no_ack", {30'd0, ack, wb_cyc_o}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 80; i++) begin
      int m, r;
      rop = ($urandom_range(0, 1) == 1) ? LOAD_DATA : STORE_DATA;
      r = $urandom_range(0, 99);
      m = (r < 80) ? 0 : (r < 88) ? 1 : (r < 96) ? 2 : 3;
      run_txn(rop, 3'($urandom_range(0, 7)), $urandom, 32'($urandom_range(0, 15)),
              $urandom, m, $urandom_range(0, 3), $urandom);
    end

    repeat (3) @(negedge clk);
    check32("queues_drained", bus_q.size() + rsp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
